// File: rtl/counter_sched_pkg.sv
// Shared definitions for the counter_sched round-robin counter scheduler:
// the scheduler state encoding and the default counter/data width.
package counter_sched_pkg;

    // Width of the shared up/down counter datapath
    localparam int W_DEFAULT = 8;

    // Scheduler states, one job at a time walks IDLE -> LOAD -> RUN -> DONE
    typedef enum logic [2:0] {
        INIT,
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/counter_sched_rr_arbiter.sv
// Combinational round-robin arbiter for counter_sched. Searches the request
// vector starting one position after the last granted index, wrapping
// modulo NREQ, and returns the winner both one-hot and as an index.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   index,
    output logic            valid
);

    // First requester found after ptr wins; the last-served one is checked last
    always_comb begin
        int cand;
        grant = '0;
        index = '0;
        valid = 1'b0;
        cand  = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(ptr) + k) % NREQ;
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                index       = IW'(cand);
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/counter_sched.sv
// counter_sched: shares one external W-bit up/down counter between NREQ
// requesters in round-robin order. A granted job loads its start value,
// counts len steps in the requested direction, and the final counter value
// is returned with a one-cycle done pulse. The counter free-runs unless set,
// so between jobs it is held by reloading a shadow copy kept here; the same
// shadow is compared against the counter when the job completes.
// Optional feature: define COUNTER_SCHED_ABORT_EN to let a requester cancel
// a running job by dropping req; without it req is ignored after grant and
// aborted is tied to 0.
module counter_sched
    import counter_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   dir,
    input  logic [NREQ*W-1:0] start,
    input  logic [NREQ*W-1:0] len,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [W-1:0]      result,
    output logic              aborted,
    output logic              mismatch,
    output logic              ctr_reset,
    output logic              ctr_set,
    output logic [W-1:0]      ctr_in,
    output logic              ctr_down,
    output logic              ctr_oe,
    input  logic [W-1:0]      ctr_out
);

    localparam int IW = $clog2(NREQ);

    state_t          state_q;
    state_t          state_d;
    logic [IW-1:0]   ptr_q;
    logic [W-1:0]    shadow_q;
    logic [W-1:0]    rem_q;
    logic            dir_q;
    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic            arb_valid;
    logic [W-1:0]    start_sel;
    logic [W-1:0]    len_sel;
    logic            abort_hit;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req   (req),
        .ptr   (ptr_q),
        .grant (arb_gnt),
        .index (arb_idx),
        .valid (arb_valid)
    );

    // ptr_q doubles as the owner of the current job once granted
    assign start_sel = start[int'(ptr_q)*W +: W];
    assign len_sel   = len[int'(ptr_q)*W +: W];

`ifdef COUNTER_SCHED_ABORT_EN
    logic abort_q;

    // A job ends early only if its owner lets go before the final step
    assign abort_hit = (state_q == RUN) && (rem_q != W'(1)) && !req[ptr_q];

    // Remember an early exit so DONE can report it alongside the result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            abort_q <= 1'b0;
            aborted <= 1'b0;
        end else begin
            aborted <= 1'b0;
            if (state_q == LOAD) begin
                abort_q <= 1'b0;
            end else if (abort_hit) begin
                abort_q <= 1'b1;
            end
            if (state_q == DONE) begin
                aborted <= abort_q;
            end
        end
    end
`else
    assign abort_hit = 1'b0;
    assign aborted   = 1'b0;
`endif

    // State register; reset always returns to INIT so the counter gets cleared
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and counter control; the counter is kept loaded except in RUN
    always_comb begin
        state_d   = state_q;
        ctr_reset = 1'b0;
        ctr_set   = 1'b0;
        ctr_in    = shadow_q;
        ctr_down  = 1'b0;
        ctr_oe    = 1'b0;
        case (state_q)
            INIT: begin
                ctr_reset = 1'b1;
                state_d   = IDLE;
            end
            IDLE: begin
                ctr_set = 1'b1;
                if (arb_valid) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                ctr_set = 1'b1;
                ctr_in  = start_sel;
                state_d = (len_sel != '0) ? RUN : DONE;
            end
            RUN: begin
                ctr_down = dir_q;
                if ((rem_q == W'(1)) || abort_hit) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                ctr_set = 1'b1;
                ctr_oe  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    // Job bookkeeping: grant, shadow tracking of the counter, and completion
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt      <= '0;
            done     <= '0;
            result   <= '0;
            mismatch <= 1'b0;
            shadow_q <= '0;
            rem_q    <= '0;
            dir_q    <= 1'b0;
            ptr_q    <= IW'(NREQ - 1);
        end else begin
            done     <= '0;
            mismatch <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (arb_valid) begin
                        gnt   <= arb_gnt;
                        ptr_q <= arb_idx;
                    end
                end
                LOAD: begin
                    shadow_q <= start_sel;
                    rem_q    <= len_sel;
                    dir_q    <= dir[ptr_q];
                end
                RUN: begin
                    shadow_q <= dir_q ? (shadow_q - 1'b1) : (shadow_q + 1'b1);
                    rem_q    <= rem_q - 1'b1;
                end
                DONE: begin
                    done     <= gnt;
                    result   <= ctr_out;
                    mismatch <= (ctr_out != shadow_q);
                    gnt      <= '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_sched.sv
// Self-checking bench for counter_sched. Models the external counter
// behaviourally, issues batches of jobs, predicts service order and results
// with a round-robin model, and checks done/result/aborted/mismatch, grant
// ownership and grant duration from a separate monitor.
module tb_counter_sched;

    localparam int NREQ = 4;
    localparam int W    = 8;
`ifdef COUNTER_SCHED_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    typedef struct {
        logic [7:0] start;
        int         len;
        bit         dir;
        int         drop;
    } job_t;

    typedef struct {
        int         idx;
        logic [7:0] result;
        bit         aborted;
        int         cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ-1:0]   dir = '0;
    logic [NREQ*W-1:0] start = '0;
    logic [NREQ*W-1:0] len = '0;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic [W-1:0]      result;
    logic              aborted;
    logic              mismatch;
    logic              ctr_reset;
    logic              ctr_set;
    logic [W-1:0]      ctr_in;
    logic              ctr_down;
    logic              ctr_oe;
    logic [W-1:0]      ctr_q = 8'h5A;
    wire  [W-1:0]      ctr_bus;

    job_t jobs[NREQ][$];
    exp_t exp_q[$];
    int   rr = NREQ - 1;
    int   batch_id = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   gcyc = 0;

    counter_sched #(
        .NREQ (NREQ),
        .W    (W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .dir       (dir),
        .start     (start),
        .len       (len),
        .gnt       (gnt),
        .done      (done),
        .result    (result),
        .aborted   (aborted),
        .mismatch  (mismatch),
        .ctr_reset (ctr_reset),
        .ctr_set   (ctr_set),
        .ctr_in    (ctr_in),
        .ctr_down  (ctr_down),
        .ctr_oe    (ctr_oe),
        .ctr_out   (ctr_bus)
    );

    always #5 clk = ~clk;

    // External counter: sync clear, load, otherwise counts every clock
    always @(posedge clk) begin
        if (ctr_reset)     ctr_q <= '0;
        else if (ctr_set)  ctr_q <= ctr_in;
        else if (ctr_down) ctr_q <= ctr_q - 8'd1;
        else               ctr_q <= ctr_q + 8'd1;
    end

    assign ctr_bus = ctr_oe ? ctr_q : 8'bz;

    function automatic logic [31:0] onehot(input int i);
        return 32'(1) << i;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic addJob(input int i, input logic [7:0] s, input int l, input bit d, input int drop);
        job_t j;
        j.start = s;
        j.len   = l;
        j.dir   = d;
        j.drop  = drop;
        jobs[i].push_back(j);
    endtask

    function automatic bit anyJobs();
        for (int i = 0; i < NREQ; i++) if (jobs[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    // Predict service order: round robin over requesters that still hold work
    task automatic planBatch();
        int   used[NREQ];
        int   remain;
        int   runs;
        bit   found;
        job_t j;
        exp_t e;
        remain = 0;
        for (int i = 0; i < NREQ; i++) begin
            used[i] = 0;
            remain += jobs[i].size();
        end
        while (remain > 0) begin
            found = 1'b0;
            for (int k = 1; k <= NREQ; k++) begin
                int c;
                c = (rr + k) % NREQ;
                if (!found && used[c] < jobs[c].size()) begin
                    found = 1'b1;
                    j = jobs[c][used[c]];
                    runs = (ABORT_EN && j.drop > 0 && j.drop < j.len) ? j.drop : j.len;
                    e.idx     = c;
                    e.result  = j.dir ? 8'(int'(j.start) - runs) : 8'(int'(j.start) + runs);
                    e.aborted = (runs < j.len);
                    e.cyc     = runs + 2;
                    exp_q.push_back(e);
                    used[c]++;
                    rr = c;
                    remain--;
                end
            end
        end
    endtask

    task automatic waitDone(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || anyJobs()) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0 || anyJobs()) begin
            checkOutput("batch_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            for (int i = 0; i < NREQ; i++) jobs[i].delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic applyStimulus(input int budget);
        @(negedge clk);
        planBatch();
        batch_id++;
        waitDone(budget);
    endtask

    // Requester drivers: raise all queued jobs together, advance or drop on done
    always @(negedge clk) begin
        static int seen_id = 0;
        static int gneg[NREQ] = '{default: 0};
        if (!reset) begin
            req = '0;
            for (int i = 0; i < NREQ; i++) gneg[i] = 0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (done[i]) begin
                    if (jobs[i].size() > 0) void'(jobs[i].pop_front());
                    if (jobs[i].size() > 0) begin
                        start[i*W +: W] = jobs[i][0].start;
                        len[i*W +: W]   = 8'(jobs[i][0].len);
                        dir[i]          = jobs[i][0].dir;
                    end else begin
                        req[i] = 1'b0;
                    end
                end
                if (gnt[i]) begin
                    gneg[i]++;
                    if (jobs[i].size() > 0 && jobs[i][0].drop > 0 && gneg[i] == jobs[i][0].drop + 1)
                        req[i] = 1'b0;
                end else begin
                    gneg[i] = 0;
                end
            end
            if (batch_id != seen_id) begin
                seen_id = batch_id;
                for (int i = 0; i < NREQ; i++) begin
                    if (jobs[i].size() > 0) begin
                        start[i*W +: W] = jobs[i][0].start;
                        len[i*W +: W]   = 8'(jobs[i][0].len);
                        dir[i]          = jobs[i][0].dir;
                        req[i]          = 1'b1;
                    end
                end
            end
        end
    end

    // Monitor: grant ownership every cycle, full completion check on each done
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            gcyc = 0;
        end else begin
            if (gnt != '0) begin
                gcyc++;
                if (exp_q.size() == 0) checkOutput("gnt_unexpected", 32'(gnt), 32'd0);
                else                   checkOutput("gnt_owner", 32'(gnt), onehot(exp_q[0].idx));
            end
            if (done != '0) begin
                if (exp_q.size() == 0) begin
                    checkOutput("done_unexpected", 32'(done), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("done_onehot", 32'(done), onehot(e.idx));
                    checkOutput("result", 32'(result), 32'(e.result));
                    checkOutput("aborted", 32'(aborted), 32'(e.aborted));
                    checkOutput("mismatch", 32'(mismatch), 32'd0);
                    checkOutput("gnt_cycles", 32'(gcyc), 32'(e.cyc));
                end
                gcyc = 0;
            end
        end
    end

    initial begin
        // Reset state and counter clearing while held in reset
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_gnt", 32'(gnt), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_result", 32'(result), 32'd0);
        checkOutput("rst_aborted", 32'(aborted), 32'd0);
        checkOutput("rst_mismatch", 32'(mismatch), 32'd0);
        checkOutput("rst_ctr_reset", 32'(ctr_reset), 32'd1);
        checkOutput("rst_ctr_oe", 32'(ctr_oe), 32'd0);
        checkOutput("rst_ctr_q", 32'(ctr_q), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("idle_ctr_reset", 32'(ctr_reset), 32'd0);
        checkOutput("idle_ctr_set", 32'(ctr_set), 32'd1);
        checkOutput("idle_ctr_in", 32'(ctr_in), 32'd0);
        checkOutput("idle_ctr_down", 32'(ctr_down), 32'd0);

        // Basic up count, down wrap, up wrap
        addJob(0, 8'h10, 5, 1'b0, 0);
        applyStimulus(200);
        addJob(1, 8'h02, 4, 1'b1, 0);
        applyStimulus(200);
        addJob(2, 8'hFE, 3, 1'b0, 0);
        applyStimulus(200);

        // All four held with len=1, requester 0 twice: must wait behind the rest
        for (int i = 0; i < NREQ; i++) addJob(i, 8'($urandom), 1, 1'($urandom_range(0, 1)), 0);
        addJob(0, 8'h33, 1, 1'b0, 0);
        applyStimulus(300);

        // Zero-length job goes straight to DONE and the counter holds the value
        addJob(3, 8'hA5, 0, 1'b0, 0);
        applyStimulus(200);
        repeat (3) @(negedge clk);
        checkOutput("hold_ctr_q", 32'(ctr_q), 32'hA5);
        checkOutput("hold_ctr_in", 32'(ctr_in), 32'hA5);

        // Longest job, and down-count across zero
        addJob(2, 8'h80, 255, 1'b0, 0);
        applyStimulus(600);
        addJob(1, 8'h01, 200, 1'b1, 0);
        applyStimulus(600);

        // Requester drops req after two RUN cycles
        addJob(3, 8'h00, 10, 1'b0, 2);
        applyStimulus(200);

        // Reset in the middle of a running job: dropped without a done pulse
        addJob(1, 8'h30, 20, 1'b0, 0);
        @(negedge clk);
        planBatch();
        batch_id++;
        repeat (8) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checkOutput("midrst_gnt", 32'(gnt), 32'd0);
        checkOutput("midrst_done", 32'(done), 32'd0);
        checkOutput("midrst_result", 32'(result), 32'd0);
        checkOutput("midrst_ctr_reset", 32'(ctr_reset), 32'd1);
        checkOutput("midrst_ctr_oe", 32'(ctr_oe), 32'd0);
        exp_q.delete();
        for (int i = 0; i < NREQ; i++) jobs[i].delete();
        rr = NREQ - 1;
        repeat (2) @(negedge clk);
        checkOutput("midrst_ctr_q", 32'(ctr_q), 32'd0);
        reset = 1'b1;
        #1;
        checkOutput("init_ctr_reset", 32'(ctr_reset), 32'd1);
        @(negedge clk);
        checkOutput("post_ctr_reset", 32'(ctr_reset), 32'd0);
        checkOutput("post_ctr_set", 32'(ctr_set), 32'd1);
        checkOutput("post_ctr_q", 32'(ctr_q), 32'd0);
        @(negedge clk);
        checkOutput("post_hold_ctr_q", 32'(ctr_q), 32'd0);

        // Randomized batches of zero to two jobs per requester
        for (int b = 0; b < 25; b++) begin
            int total;
            total = 0;
            for (int i = 0; i < NREQ; i++) begin
                int n;
                n = $urandom_range(0, 2);
                for (int k = 0; k < n; k++) begin
                    addJob(i, 8'($urandom), $urandom_range(0, 12), 1'($urandom_range(0, 1)), 0);
                    total++;
                end
            end
            if (total == 0) addJob($urandom_range(0, NREQ - 1), 8'($urandom), $urandom_range(0, 40), 1'b1, 0);
            applyStimulus(2000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
